// File: rtl/cgra_soc_pkg.sv
// cgra_soc_pkg: shared CGRA packet geometry, FSM state types and beat pack/unpack helpers
package cgra_soc_pkg;

    localparam int AXIS_W = 64;
    localparam int PKT_W  = 217;
    localparam int BEATS  = (PKT_W + AXIS_W - 1) / AXIS_W;

    typedef logic [AXIS_W-1:0]             beat_t;
    typedef logic [BEATS-1:0][AXIS_W-1:0]  beats_t;
    typedef logic [PKT_W-1:0]              pkt_t;

    typedef enum logic {RX_COLLECT = 1'b0, RX_HOLD = 1'b1} rx_state_e;
    typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;

    // Beats concatenated LSB first; pad bits above PKT_W are dropped.
    function automatic pkt_t pack_pkt(input beats_t b);
        logic [BEATS*AXIS_W-1:0] f;
        f = b;
        return f[PKT_W-1:0];
    endfunction

    // Packet split into beats with the pad bits of the last beat forced to 0.
    function automatic beats_t unpack_pkt(input pkt_t p);
        logic [BEATS*AXIS_W-1:0] f;
        f = '0;
        f[PKT_W-1:0] = p;
        return f;
    endfunction

endpackage

// File: rtl/cgra_beat_mux.sv
// cgra_beat_mux: selects beat idx out of a captured, pad-extended packet
module cgra_beat_mux #(
    parameter int AXIS_W = 64,
    parameter int BEATS  = 4,
    parameter int CW     = 2
) (
    input  logic [BEATS*AXIS_W-1:0] pkt,
    input  logic [CW-1:0]           idx,
    output logic [AXIS_W-1:0]       beat
);

    assign beat = pkt[idx*AXIS_W +: AXIS_W];

endmodule

// File: rtl/cgra_stream_serdes.sv
// cgra_stream_serdes: AXI-Stream beats <-> flat CGRA packets, with independent RX and TX paths
module cgra_stream_serdes #(
    parameter int AXIS_W = 64,
    parameter int PKT_W  = 217
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [AXIS_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [PKT_W-1:0]  recv_pkt_msg,
    output logic              recv_pkt_val,
    input  logic              recv_pkt_rdy,
    input  logic [PKT_W-1:0]  send_pkt_msg,
    input  logic              send_pkt_val,
    output logic              send_pkt_rdy,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [7:0]        rx_err_cnt,
    output logic [15:0]       rx_pkt_cnt,
    output logic [15:0]       tx_pkt_cnt
);
    import cgra_soc_pkg::*;

    localparam int BEATS = (PKT_W + AXIS_W - 1) / AXIS_W;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int BUF_W = BEATS * AXIS_W;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    rx_state_e         rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic              disc_q, disc_d;
    logic [PKT_W-1:0]  rx_buf_q, rx_buf_d;
    logic [7:0]        rx_err_q, rx_err_d;
    logic [15:0]       rx_pkt_q, rx_pkt_d;

    tx_state_e         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BUF_W-1:0]  tx_buf_q, tx_buf_d;
    logic [15:0]       tx_pkt_q, tx_pkt_d;
    logic [AXIS_W-1:0] tx_beat;

    // RX: collect beats into the packet buffer, drop malformed packets, hold until the CGRA takes it
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        disc_d     = disc_q;
        rx_buf_d   = rx_buf_q;
        rx_err_d   = rx_err_q;
        rx_pkt_d   = rx_pkt_q;
        if (rx_state_q == RX_HOLD) begin
            if (recv_pkt_rdy) begin
                rx_state_d = RX_COLLECT;
                rx_pkt_d   = rx_pkt_q + 16'd1;
            end
        end else if (s_axis_tvalid) begin
            if (disc_q) begin
                disc_d = !s_axis_tlast;
            end else begin
                for (int i = 0; i < PKT_W; i++)
                    if (i / AXIS_W == int'(rx_cnt_q)) rx_buf_d[i] = s_axis_tdata[i % AXIS_W];
                rx_cnt_d = (rx_cnt_q == LAST || s_axis_tlast) ? '0 : rx_cnt_q + CW'(1);
                if (rx_cnt_q == LAST && s_axis_tlast) begin
                    rx_state_d = RX_HOLD;
                end else if (rx_cnt_q == LAST || s_axis_tlast) begin
                    rx_err_d = rx_err_q + {7'd0, rx_err_q != 8'hff};
                    disc_d   = !s_axis_tlast;
                end
            end
        end
    end

    // RX state and data registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_q <= RX_COLLECT;
            rx_cnt_q   <= '0;
            disc_q     <= 1'b0;
            rx_buf_q   <= '0;
            rx_err_q   <= '0;
            rx_pkt_q   <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            disc_q     <= disc_d;
            rx_buf_q   <= rx_buf_d;
            rx_err_q   <= rx_err_d;
            rx_pkt_q   <= rx_pkt_d;
        end
    end

    // TX: capture a packet (pad forced to zero) and walk it out beat by beat
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_buf_d   = tx_buf_q;
        tx_pkt_d   = tx_pkt_q;
        if (tx_state_q == TX_IDLE) begin
            if (send_pkt_val) begin
                tx_buf_d   = BUF_W'(send_pkt_msg);
                tx_cnt_d   = '0;
                tx_state_d = TX_SEND;
            end
        end else if (m_axis_tready) begin
            tx_cnt_d = tx_cnt_q == LAST ? '0 : tx_cnt_q + CW'(1);
            if (tx_cnt_q == LAST) begin
                tx_state_d = TX_IDLE;
                tx_pkt_d   = tx_pkt_q + 16'd1;
            end
        end
    end

    // TX state and data registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_buf_q   <= '0;
            tx_pkt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_buf_q   <= tx_buf_d;
            tx_pkt_q   <= tx_pkt_d;
        end
    end

    cgra_beat_mux #(.AXIS_W(AXIS_W), .BEATS(BEATS), .CW(CW)) u_beat_mux (
        .pkt  (tx_buf_q),
        .idx  (tx_cnt_q),
        .beat (tx_beat)
    );

    assign s_axis_tready = rx_state_q == RX_COLLECT;
    assign recv_pkt_val  = rx_state_q == RX_HOLD;
    assign recv_pkt_msg  = rx_buf_q;
    assign send_pkt_rdy  = tx_state_q == TX_IDLE;
    assign m_axis_tvalid = tx_state_q == TX_SEND;
    assign m_axis_tlast  = m_axis_tvalid && tx_cnt_q == LAST;
    assign m_axis_tdata  = m_axis_tvalid ? tx_beat : '0;
    assign rx_err_cnt    = rx_err_q;
    assign rx_pkt_cnt    = rx_pkt_q;
    assign tx_pkt_cnt    = tx_pkt_q;

endmodule

// File: tb/tb_cgra_stream_serdes.sv
// tb_cgra_stream_serdes: directed and randomized checks of the stream serdes against a packet-level model
module tb_cgra_stream_serdes;
    import cgra_soc_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    beat_t       s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    pkt_t        recv_pkt_msg;
    logic        recv_pkt_val, recv_pkt_rdy = 1'b1;
    pkt_t        send_pkt_msg = '0;
    logic        send_pkt_val = 1'b0, send_pkt_rdy;
    beat_t       m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
    logic [7:0]  rx_err_cnt;
    logic [15:0] rx_pkt_cnt, tx_pkt_cnt;

    int  n_chk = 0, n_fail = 0;
    bit  rand_mtr = 0, rand_rdy = 0;

    always #5 clk = ~clk;

    cgra_stream_serdes #(.AXIS_W(AXIS_W), .PKT_W(PKT_W)) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .recv_pkt_msg(recv_pkt_msg), .recv_pkt_val(recv_pkt_val), .recv_pkt_rdy(recv_pkt_rdy),
        .send_pkt_msg(send_pkt_msg), .send_pkt_val(send_pkt_val), .send_pkt_rdy(send_pkt_rdy),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .rx_err_cnt(rx_err_cnt), .rx_pkt_cnt(rx_pkt_cnt), .tx_pkt_cnt(tx_pkt_cnt)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Packet-level model: a list of beats per packet, a held packet, and a queue of outgoing beats
    beat_t rx_cur[$];
    bit    m_disc, m_hold;
    pkt_t  m_held;
    int    m_err, m_rxcnt;
    beat_t tx_q[$];
    bit    m_busy;
    int    m_txcnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_cur.delete();
            m_disc = 0; m_hold = 0; m_held = '0; m_err = 0; m_rxcnt = 0;
            tx_q.delete();
            m_busy = 0; m_txcnt = 0;
        end else begin
            if (m_hold) begin
                if (recv_pkt_rdy) begin
                    m_hold = 0;
                    m_rxcnt = (m_rxcnt + 1) % 65536;
                end
            end else if (s_axis_tvalid) begin
                if (m_disc) begin
                    if (s_axis_tlast) m_disc = 0;
                end else begin
                    rx_cur.push_back(s_axis_tdata);
                    if (s_axis_tlast && rx_cur.size() == BEATS) begin
                        beats_t b;
                        for (int i = 0; i < BEATS; i++) b[i] = rx_cur[i];
                        m_held = pack_pkt(b);
                        m_hold = 1;
                        rx_cur.delete();
                    end else if (s_axis_tlast || rx_cur.size() == BEATS) begin
                        if (m_err < 255) m_err++;
                        m_disc = !s_axis_tlast;
                        rx_cur.delete();
                    end
                end
            end
            if (m_busy) begin
                if (m_axis_tready) begin
                    void'(tx_q.pop_front());
                    if (tx_q.size() == 0) begin
                        m_busy = 0;
                        m_txcnt = (m_txcnt + 1) % 65536;
                    end
                end
            end else if (send_pkt_val) begin
                beats_t b;
                b = unpack_pkt(send_pkt_msg);
                for (int i = 0; i < BEATS; i++) tx_q.push_back(b[i]);
                m_busy = 1;
            end
        end
    end

    // Every cycle, compare all visible DUT outputs with the model on the falling edge
    always @(negedge clk) begin
        chk("s_axis_tready", 256'(s_axis_tready), 256'(!m_hold));
        chk("recv_pkt_val", 256'(recv_pkt_val), 256'(m_hold));
        if (m_hold) chk("recv_pkt_msg", 256'(recv_pkt_msg), 256'(m_held));
        chk("rx_err_cnt", 256'(rx_err_cnt), 256'(m_err));
        chk("rx_pkt_cnt", 256'(rx_pkt_cnt), 256'(m_rxcnt));
        chk("send_pkt_rdy", 256'(send_pkt_rdy), 256'(!m_busy));
        chk("m_axis_tvalid", 256'(m_axis_tvalid), 256'(m_busy));
        if (m_busy) begin
            chk("m_axis_tdata", 256'(m_axis_tdata), 256'(tx_q[0]));
            chk("m_axis_tlast", 256'(m_axis_tlast), 256'(tx_q.size() == 1));
        end
        if (!rstn) begin
            chk("rst_tdata", 256'(m_axis_tdata), 256'(0));
            chk("rst_tlast", 256'(m_axis_tlast), 256'(0));
        end
        chk("tx_pkt_cnt", 256'(tx_pkt_cnt), 256'(m_txcnt));
    end

    // Random backpressure sources, updated just after each rising edge
    initial forever begin
        @(posedge clk); #1;
        if (rand_mtr) m_axis_tready = 1'($urandom_range(0, 1));
        if (rand_rdy) recv_pkt_rdy = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic beat_t rnd_beat();
        return {$urandom, $urandom};
    endfunction

    function automatic pkt_t rnd_pkt();
        beats_t b;
        for (int i = 0; i < BEATS; i++) b[i] = rnd_beat();
        return pack_pkt(b);
    endfunction

    task automatic rx_beat(input beat_t d, input bit last);
        bit h = 0;
        int n = 0;
        s_axis_tdata = d; s_axis_tlast = last; s_axis_tvalid = 1'b1;
        do begin
            @(negedge clk); h = s_axis_tready;
            @(posedge clk); #1; n++;
        end while (!h && n < 500);
        if (!h) begin n_chk++; n_fail++; $display("FAIL rx_beat: handshake timeout"); end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic rx_pkt(input beats_t b);
        for (int i = 0; i < BEATS; i++) rx_beat(b[i], i == BEATS - 1);
    endtask

    task automatic tx_pkt(input pkt_t p);
        bit h = 0;
        int n = 0;
        send_pkt_msg = p; send_pkt_val = 1'b1;
        do begin
            @(negedge clk); h = send_pkt_rdy;
            @(posedge clk); #1; n++;
        end while (!h && n < 500);
        if (!h) begin n_chk++; n_fail++; $display("FAIL tx_pkt: handshake timeout"); end
        send_pkt_val = 1'b0;
    endtask

    task automatic tx_wait(input int k, output int got, output int tl_n, output int tl_idx, output beat_t last_beat);
        int n = 0;
        got = 0; tl_n = 0; tl_idx = -1; last_beat = '0;
        while (got < k && n < 1000) begin
            @(negedge clk); n++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (m_axis_tlast) begin tl_n++; tl_idx = got; end
                last_beat = m_axis_tdata;
                got++;
            end
        end
        @(posedge clk); #1;
        if (got < k) begin n_chk++; n_fail++; $display("FAIL tx_wait: got %0d beats expected %0d", got, k); end
    endtask

    task automatic wait_rx_deliver(input int target);
        int n = 0;
        while (m_rxcnt != target && n < 500) begin @(posedge clk); #1; n++; end
        chk("rx_deliver", 256'(rx_pkt_cnt), 256'(target));
    endtask

    initial begin
        beats_t b;
        pkt_t   e, p;
        int     got, tl_n, tl_idx;
        beat_t  lb;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 256'(s_axis_tready), 256'(1));
        chk("rst_recv_val", 256'(recv_pkt_val), 256'(0));
        chk("rst_send_rdy", 256'(send_pkt_rdy), 256'(1));
        chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_counters", 256'({rx_err_cnt, rx_pkt_cnt, tx_pkt_cnt}), 256'(0));
        rstn = 1'b1;
        @(posedge clk); #1;

        // Basic packet: beats 1..4, consumer always ready
        rx_beat(64'h1, 0); rx_beat(64'h2, 0); rx_beat(64'h3, 0); rx_beat(64'h4, 1);
        @(negedge clk);
        chk("t1_val", 256'(recv_pkt_val), 256'(1));
        chk("t1_msg_lo", 256'(recv_pkt_msg[63:0]), 256'(64'h1));
        chk("t1_msg_b2", 256'(recv_pkt_msg[191:128]), 256'(64'h3));
        chk("t1_msg_b3", 256'(recv_pkt_msg[216:192]), 256'(25'h4));
        @(posedge clk); #1;
        chk("t1_rx_pkt_cnt", 256'(rx_pkt_cnt), 256'(1));

        // Consumer stalls for 10 cycles: packet must be held and input blocked
        recv_pkt_rdy = 1'b0;
        for (int i = 0; i < BEATS; i++) b[i] = rnd_beat();
        e = pack_pkt(b);
        rx_pkt(b);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_tready", 256'(s_axis_tready), 256'(0));
            chk("t2_msg", 256'(recv_pkt_msg), 256'(e));
        end
        @(posedge clk); #1; recv_pkt_rdy = 1'b1;
        @(posedge clk); #1;
        chk("t2_rx_pkt_cnt", 256'(rx_pkt_cnt), 256'(2));

        // Early tlast on beat 1, then a good packet
        rx_beat(rnd_beat(), 0); rx_beat(rnd_beat(), 1);
        chk("t3_err", 256'(rx_err_cnt), 256'(1));
        for (int i = 0; i < BEATS; i++) b[i] = rnd_beat();
        rx_pkt(b);
        @(posedge clk); #1;
        chk("t3_rx_pkt_cnt", 256'(rx_pkt_cnt), 256'(3));

        // Over-long packet: six beats, tlast on beat 5, then a good packet
        for (int i = 0; i < 6; i++) rx_beat(rnd_beat(), i == 5);
        chk("t4_err", 256'(rx_err_cnt), 256'(2));
        chk("t4_rx_pkt_cnt", 256'(rx_pkt_cnt), 256'(3));
        for (int i = 0; i < BEATS; i++) b[i] = rnd_beat();
        rx_pkt(b);
        @(posedge clk); #1;
        chk("t4_rx_pkt_cnt_after", 256'(rx_pkt_cnt), 256'(4));

        // TX packet under 50% random backpressure
        rand_mtr = 1;
        p = rnd_pkt();
        p[PKT_W-1] = 1'b1;
        tx_pkt(p);
        tx_wait(BEATS, got, tl_n, tl_idx, lb);
        chk("t5_beats", 256'(got), 256'(4));
        chk("t5_tlast_n", 256'(tl_n), 256'(1));
        chk("t5_tlast_idx", 256'(tl_idx), 256'(3));
        chk("t5_pad", 256'(lb[63:25]), 256'(0));
        chk("t5_top_bit", 256'(lb[24]), 256'(1));
        chk("t5_tx_pkt_cnt", 256'(tx_pkt_cnt), 256'(1));

        // Random concurrent traffic in both directions, including malformed RX packets
        rand_rdy = 1;
        fork
            for (int k = 0; k < 25; k++) begin
                int len;
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : BEATS;
                for (int i = 0; i < len; i++) rx_beat(rnd_beat(), i == len - 1);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            for (int k = 0; k < 25; k++) begin
                tx_pkt(rnd_pkt());
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        join
        rand_rdy = 0; rand_mtr = 0;
        @(posedge clk); #1;
        recv_pkt_rdy = 1'b1; m_axis_tready = 1'b1;
        repeat (12) begin @(posedge clk); #1; end

        // Reset in the middle of an RX packet and a TX packet
        for (int i = 0; i < 3; i++) rx_beat(rnd_beat(), 0);
        tx_pkt(rnd_pkt());
        tx_wait(2, got, tl_n, tl_idx, lb);
        m_axis_tready = 1'b0;
        rstn = 1'b0;
        #1;
        chk("r_s_tready", 256'(s_axis_tready), 256'(1));
        chk("r_recv_val", 256'(recv_pkt_val), 256'(0));
        chk("r_send_rdy", 256'(send_pkt_rdy), 256'(1));
        chk("r_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("r_m_tlast", 256'(m_axis_tlast), 256'(0));
        chk("r_m_tdata", 256'(m_axis_tdata), 256'(0));
        chk("r_counters", 256'({rx_err_cnt, rx_pkt_cnt, tx_pkt_cnt}), 256'(0));
        @(posedge clk); #1;
        rstn = 1'b1; m_axis_tready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < BEATS; i++) b[i] = rnd_beat();
        rx_pkt(b);
        wait_rx_deliver(1);
        chk("r_err_after", 256'(rx_err_cnt), 256'(0));
        tx_pkt(rnd_pkt());
        tx_wait(BEATS, got, tl_n, tl_idx, lb);
        chk("r_tx_pkt_cnt", 256'(tx_pkt_cnt), 256'(1));
        repeat (3) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
